// File: rtl/rs_pkg.sv
`default_nettype none
// ============================================================================
// Package     : rs_pkg
// Description : Shared helpers and types for the relay-station link (head/tail).
// Revision    : 1.0 - initial release
// ============================================================================
package rs_pkg;

   // Ceiling log2; returns at least 1 so a width derived from it is never zero.
   function automatic int rs_clog2(input int value);
      int result;
      result = 0;
      while ((1 << result) < value) begin
         result = result + 1;
      end
      if (result == 0) begin
         result = 1;
      end
      return result;
   endfunction

   // Words still in flight after full_n falls: forward stages, reverse stages, plus the credit register.
   function automatic int rs_grace(input int body_level);
      return 2 * body_level + 1;
   endfunction

   typedef struct packed {
      logic valid;
      logic credit;
   } rs_link_t;

endpackage
`default_nettype wire

// File: rtl/rs_tail_fifo_mem.sv
`default_nettype none
// ============================================================================
// Module      : rs_tail_fifo_mem
// Description : Show-ahead buffer for the relay-station tail; register array,
//               wrap-compare pointers, occupancy count, registered head word.
// Revision    : 1.0 - initial release
// ============================================================================
module rs_tail_fifo_mem
   import rs_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 8,
   parameter int CW         = rs_clog2(DEPTH + 1)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd_en,
   output logic [DATA_WIDTH-1:0] dout,
   output logic                  empty_n,
`ifdef RS_TAIL_OVF_CHECK_EN
   output logic                  wr_drop,
`endif
   output logic [CW-1:0]         count_next
);

   localparam int PW = rs_clog2(DEPTH);
   localparam logic [CW-1:0] c_depth    = CW'(DEPTH);
   localparam logic [CW-1:0] c_one      = CW'(1);
   localparam logic [PW-1:0] c_last_ptr = PW'(DEPTH - 1);

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]         r_wr_ptr;
   logic [PW-1:0]         r_rd_ptr;
   logic [CW-1:0]         r_count;
   logic [DATA_WIDTH-1:0] r_dout;
   logic                  r_empty_n;

   logic                  w_pop;
   logic                  w_push;
   logic [PW-1:0]         w_wr_next;
   logic [PW-1:0]         w_rd_next;
   logic [CW-1:0]         w_count_next;
   logic [DATA_WIDTH-1:0] w_head_next;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == c_last_ptr) ? '0 : p + 1'b1;
   endfunction

   assign w_pop     = rd_en & (r_count != '0);
   assign w_push    = wr_en & ((r_count != c_depth) | w_pop);
   assign w_wr_next = ptr_inc(r_wr_ptr);
   assign w_rd_next = ptr_inc(r_rd_ptr);

   always_comb begin
      w_count_next = r_count;
      case ({w_push, w_pop})
         2'b10:   w_count_next = r_count + c_one;
         2'b01:   w_count_next = r_count - c_one;
         default: w_count_next = r_count;
      endcase
   end

   // Head word for next cycle: an arriving word only becomes head when the queue drains to it.
   always_comb begin
      w_head_next = r_dout;
      if (w_push && ((r_count == '0) || (w_pop && (r_count == c_one)))) begin
         w_head_next = wr_data;
      end else if (w_pop && (r_count > c_one)) begin
         w_head_next = r_mem[w_rd_next];
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= wr_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_count   <= '0;
         r_dout    <= '0;
         r_empty_n <= 1'b0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= w_wr_next;
         end
         if (w_pop) begin
            r_rd_ptr <= w_rd_next;
         end
         r_count   <= w_count_next;
         r_dout    <= w_head_next;
         r_empty_n <= (w_count_next != '0);
      end
   end

   assign dout       = r_dout;
   assign empty_n    = r_empty_n;
   assign count_next = w_count_next;
`ifdef RS_TAIL_OVF_CHECK_EN
   assign wr_drop    = wr_en & ~w_push;
`endif

endmodule
`default_nettype wire

// File: rtl/rs_pipeline_tail_rx.sv
`default_nettype none
// ============================================================================
// Module      : rs_pipeline_tail_rx
// Description : Tail of a pipelined relay-station link; absorbs in-flight words,
//               returns a registered full_n credit. Optional overflow flag via
//               macro RS_TAIL_OVF_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module rs_pipeline_tail_rx
   import rs_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int BODY_LEVEL = 2,
   parameter int DEPTH      = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  full_n,
   output logic [DATA_WIDTH-1:0] if_dout,
   output logic                  if_empty_n,
   input  logic                  if_read,
   output logic                  ovf_err
);

   localparam int GRACE = rs_grace(BODY_LEVEL);
   localparam int CW    = rs_clog2(DEPTH + 1);
   localparam logic [CW-1:0] c_credit_thresh = CW'(DEPTH - GRACE - 1);

   generate
      if (DEPTH < GRACE + 1) begin : g_bad_depth
         $error("rs_pipeline_tail_rx: DEPTH must be at least 2*BODY_LEVEL+2");
      end
   endgenerate

   logic [CW-1:0] w_count_next;
   logic          r_full_n;
`ifdef RS_TAIL_OVF_CHECK_EN
   logic          w_drop;
   logic          r_ovf_err;
`endif

   rs_tail_fifo_mem #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .CW         (CW)
   ) u_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .wr_en      (in_valid),
      .wr_data    (in_data),
      .rd_en      (if_read),
      .dout       (if_dout),
      .empty_n    (if_empty_n),
`ifdef RS_TAIL_OVF_CHECK_EN
      .wr_drop    (w_drop),
`endif
      .count_next (w_count_next)
   );

   // Credit leaves room for every word that can still be in flight once it falls.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_full_n <= 1'b0;
      end else begin
         r_full_n <= (w_count_next <= c_credit_thresh);
      end
   end

   assign full_n = r_full_n;

`ifdef RS_TAIL_OVF_CHECK_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ovf_err <= 1'b0;
      end else if (w_drop) begin
         r_ovf_err <= 1'b1;
      end
   end

   assign ovf_err = r_ovf_err;

`ifndef SYNTHESIS
   always @(posedge clk) begin
      if (rst_n) begin
         assert (!w_drop)
            else $warning("rs_pipeline_tail_rx: write dropped on full buffer");
      end
   end
`endif
`else
   assign ovf_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rs_pipeline_tail_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_rs_pipeline_tail_rx
// Description : Directed self-checking bench for rs_pipeline_tail_rx.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rs_pipeline_tail_rx;

   localparam int DW = 32;

   logic          clk;
   logic          rst_n;
   logic          in_valid;
   logic [DW-1:0] in_data;
   logic          full_n;
   logic [DW-1:0] if_dout;
   logic          if_empty_n;
   logic          if_read;
   logic          ovf_err;

   int total;
   int bad;

`ifdef RS_TAIL_OVF_CHECK_EN
   localparam logic c_ovf_exp = 1'b1;
`else
   localparam logic c_ovf_exp = 1'b0;
`endif

   rs_pipeline_tail_rx #(
      .DATA_WIDTH (DW),
      .BODY_LEVEL (2),
      .DEPTH      (8)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .full_n     (full_n),
      .if_dout    (if_dout),
      .if_empty_n (if_empty_n),
      .if_read    (if_read),
      .ovf_err    (ovf_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n    = 1'b0;
      in_valid = 1'b1;
      in_data  = 32'h1234_5678;
      if_read  = 1'b0;
      repeat (3) tick();
      total++;
      if (full_n !== 1'b0 || if_empty_n !== 1'b0 || if_dout !== '0 || ovf_err !== 1'b0) begin
         bad++;
         $display("FAIL reset_hold: full_n=%b empty_n=%b dout=%h ovf=%b, want 0 0 0 0",
                  full_n, if_empty_n, if_dout, ovf_err);
      end
      in_valid = 1'b0;
      rst_n    = 1'b1;
      tick();
      total++;
      if (full_n !== 1'b1 || if_empty_n !== 1'b0) begin
         bad++;
         $display("FAIL reset_release: full_n=%b empty_n=%b, want 1 0", full_n, if_empty_n);
      end
   endtask

   task automatic test_single_word();
      if_read  = 1'b1;
      tick();
      if_read  = 1'b0;
      total++;
      if (if_empty_n !== 1'b0 || full_n !== 1'b1) begin
         bad++;
         $display("FAIL read_empty_ignored: empty_n=%b full_n=%b, want 0 1", if_empty_n, full_n);
      end
      in_valid = 1'b1;
      in_data  = 32'hA5A5_0001;
      #1;
      total++;
      if (if_empty_n !== 1'b0) begin
         bad++;
         $display("FAIL no_bypass: empty_n=%b, want 0", if_empty_n);
      end
      tick();
      in_valid = 1'b0;
      total++;
      if (if_empty_n !== 1'b1 || if_dout !== 32'hA5A5_0001) begin
         bad++;
         $display("FAIL single_visible: empty_n=%b dout=%h, want 1 a5a50001", if_empty_n, if_dout);
      end
      if_read = 1'b1;
      tick();
      if_read = 1'b0;
      total++;
      if (if_empty_n !== 1'b0) begin
         bad++;
         $display("FAIL single_popped: empty_n=%b, want 0", if_empty_n);
      end
   endtask

   task automatic test_credit();
      logic [2:0] exp_full;
      exp_full = 3'b100;
      for (int i = 0; i < 8; i++) begin
         in_valid = 1'b1;
         in_data  = 32'h0000_0100 + i;
         tick();
         total++;
         if (full_n !== ((i < 2) ? exp_full[2] : 1'b0)) begin
            bad++;
            $display("FAIL credit_w%0d: full_n=%b, want %b", i, full_n, (i < 2) ? 1'b1 : 1'b0);
         end
      end
      in_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         total++;
         if (if_empty_n !== 1'b1 || if_dout !== 32'h0000_0100 + i) begin
            bad++;
            $display("FAIL credit_drain%0d: empty_n=%b dout=%h, want 1 %h",
                     i, if_empty_n, if_dout, 32'h0000_0100 + i);
         end
         if_read = 1'b1;
         tick();
      end
      if_read = 1'b0;
      total++;
      if (if_empty_n !== 1'b0 || full_n !== 1'b1) begin
         bad++;
         $display("FAIL credit_drained: empty_n=%b full_n=%b, want 0 1", if_empty_n, full_n);
      end
   endtask

   task automatic test_back_to_back();
      in_valid = 1'b1;
      if_read  = 1'b1;
      for (int k = 0; k < 100; k++) begin
         in_data = 32'hBEEF_0000 + k;
         tick();
         total++;
         if (if_empty_n !== 1'b1 || if_dout !== 32'hBEEF_0000 + k || full_n !== 1'b1) begin
            bad++;
            $display("FAIL stream%0d: empty_n=%b dout=%h full_n=%b, want 1 %h 1",
                     k, if_empty_n, if_dout, full_n, 32'hBEEF_0000 + k);
         end
      end
      in_valid = 1'b0;
      tick();
      if_read = 1'b0;
      total++;
      if (if_empty_n !== 1'b0 || full_n !== 1'b1) begin
         bad++;
         $display("FAIL stream_end: empty_n=%b full_n=%b, want 0 1", if_empty_n, full_n);
      end
   endtask

   task automatic test_overflow();
      for (int i = 0; i < 8; i++) begin
         in_valid = 1'b1;
         in_data  = 32'h0000_0200 + i;
         tick();
      end
      total++;
      if (ovf_err !== 1'b0) begin
         bad++;
         $display("FAIL ovf_before: ovf=%b, want 0", ovf_err);
      end
      in_data = 32'hDEAD_DEAD;
      tick();
      in_valid = 1'b0;
      total++;
      if (ovf_err !== c_ovf_exp || if_dout !== 32'h0000_0200) begin
         bad++;
         $display("FAIL ovf_drop: ovf=%b dout=%h, want %b 00000200", ovf_err, if_dout, c_ovf_exp);
      end
      for (int i = 0; i < 8; i++) begin
         total++;
         if (if_empty_n !== 1'b1 || if_dout !== 32'h0000_0200 + i) begin
            bad++;
            $display("FAIL ovf_drain%0d: empty_n=%b dout=%h, want 1 %h",
                     i, if_empty_n, if_dout, 32'h0000_0200 + i);
         end
         if_read = 1'b1;
         tick();
      end
      if_read = 1'b0;
      total++;
      if (if_empty_n !== 1'b0 || ovf_err !== c_ovf_exp) begin
         bad++;
         $display("FAIL ovf_sticky: empty_n=%b ovf=%b, want 0 %b", if_empty_n, ovf_err, c_ovf_exp);
      end
   endtask

   task automatic test_async_reset();
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         in_data  = 32'h0000_0300 + i;
         tick();
      end
      total++;
      if (if_empty_n !== 1'b1 || if_dout !== 32'h0000_0300 || full_n !== 1'b0) begin
         bad++;
         $display("FAIL arst_pre: empty_n=%b dout=%h full_n=%b, want 1 00000300 0",
                  if_empty_n, if_dout, full_n);
      end
      #2;
      rst_n = 1'b0;
      #1;
      total++;
      if (if_empty_n !== 1'b0 || full_n !== 1'b0 || if_dout !== '0 || ovf_err !== 1'b0) begin
         bad++;
         $display("FAIL arst_immediate: empty_n=%b full_n=%b dout=%h ovf=%b, want 0 0 0 0",
                  if_empty_n, full_n, if_dout, ovf_err);
      end
      repeat (2) tick();
      in_valid = 1'b0;
      rst_n    = 1'b1;
      tick();
      total++;
      if (if_empty_n !== 1'b0 || full_n !== 1'b1) begin
         bad++;
         $display("FAIL arst_release: empty_n=%b full_n=%b, want 0 1", if_empty_n, full_n);
      end
      in_valid = 1'b1;
      in_data  = 32'h0000_0400;
      tick();
      in_valid = 1'b0;
      total++;
      if (if_empty_n !== 1'b1 || if_dout !== 32'h0000_0400) begin
         bad++;
         $display("FAIL arst_fresh: empty_n=%b dout=%h, want 1 00000400", if_empty_n, if_dout);
      end
   endtask

   initial begin
      total    = 0;
      bad      = 0;
      rst_n    = 1'b0;
      in_valid = 1'b0;
      in_data  = '0;
      if_read  = 1'b0;
      test_reset();
      test_single_word();
      test_credit();
      test_back_to_back();
      test_overflow();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
